async_fifo_1clk: RTL and testbench
==================================

// Module: async_fifo_1clk
// PURPOSE
//  Single-clock FIFO with the async_fifo port set and flag semantics (winc/rinc, wfull/rempty).
//  Buffers DSIZE-bit words between a producer and a consumer sharing wclk.
//  Drop-in stand-in for the dual-clock FIFO wherever both sides run on one clock.
// PARAMETERS
//  DSIZE  8  data word width in bits
//  ASIZE  4  address width; depth = 2**ASIZE words
// PORTS
//  wclk    in   1          single clock; all logic on its rising edge
//  wrst_n  in   1          reset, asynchronous, active-low
//  winc    in   1          write request; accepted when winc && !wfull
//  wdata   in   DSIZE      write data, captured on accepted write
//  wfull   out  1          FIFO holds 2**ASIZE words
//  rinc    in   1          read request; accepted when rinc && !rempty
//  rdata   out  DSIZE      head-of-FIFO word (first-word-fall-through)
//  rempty  out  1          FIFO holds 0 words
// BEHAVIOUR
//  - Reset: asynchronous on wrst_n low. Write and read pointers = 0. wfull=0, rempty=1.
//    Memory contents are not reset, so rdata is don't-care while rempty=1.
//  - Pointers: wptr and rptr are ASIZE+1 bits. The low ASIZE bits address memory.
//    The MSB is a wrap bit; increments wrap modulo 2**(ASIZE+1).
//  - Write: on posedge with winc && !wfull, mem[wptr[ASIZE-1:0]] <= wdata and wptr++.
//    winc while wfull is ignored: no pointer or memory change.
//  - Read: rdata = mem[rptr[ASIZE-1:0]], combinational, valid whenever !rempty.
//    On posedge with rinc && !rempty, rptr++. rinc while rempty is ignored.
//  - Flags are registered from next-state pointers and are valid the cycle after the causing edge:
//    rempty_next = (wptr_next == rptr_next)
//    wfull_next = (wptr_next == {~rptr_next[ASIZE], rptr_next[ASIZE-1:0]})
//  - Simultaneous winc and rinc:
//    when empty, only the write is taken (rempty -> 0);
//    when full, only the read is taken (wfull -> 0);
//    otherwise both are taken and the occupancy is unchanged.
//  - Data order is strict FIFO; no word is lost or duplicated across pointer wrap.
//  - Reset asserted mid-operation discards all contents immediately and returns to the reset state.
// CONFIGURATION
//  ASYNC_FIFO_COUNT_EN defined: adds output port wcount [ASIZE:0].
//    wcount is a registered occupancy (0 .. 2**ASIZE), updated on the same edge as the flags, 0 in reset.
//  ASYNC_FIFO_COUNT_EN undefined: the port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package async_fifo_pkg holds:
//    the DEF_DSIZE=8 / DEF_ASIZE=4 constants;
//    the typedef ptr_t [ASIZE:0] (parameterised via a localparam);
//    the function ptr_inc().
//  - Single sub-module fifo_mem:
//    DSIZE x 2**ASIZE array, registered write port, combinational read port.
//    No reset on the array.
//  - Top level holds the pointers, the flag registers and the optional counter.
// TESTING  (DSIZE=8, ASIZE=6, depth 64)
//  1 Reset: hold wrst_n=0 for 10 clocks, winc=rinc=0 -> rempty=1, wfull=0 (wcount=0).
//    Release -> flags unchanged.
//  2 Fill: 64 writes of 0x00..0x3F -> wfull=1 after the 64th edge.
//    A 65th write with 0xAA is ignored: the head stays 0x00.
//  3 Drain: 64 reads -> rdata sequence 0x00..0x3F; rempty=1 after the last read.
//    An extra rinc leaves the pointers unchanged.
//  4 Wrap: write 30 / read 30 in alternating-cycle bursts, repeated 2x with $urandom data.
//    -> every read returns the matching written word; flags never mismatch the model count.
//  5 Simultaneous: winc=rinc=1 when empty -> one word stored, rempty=0.
//    When full -> one word read, wfull=0. When half full -> occupancy stays 32.
//  6 Mid-operation reset: with 20 words stored, pulse wrst_n low asynchronously between edges
//    -> rempty=1 and wfull=0 immediately; the next write/read pair returns the new data.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared definitions for the single-clock FIFO with async_fifo port set.
// Default geometry, a pointer type for the default geometry and the
// wrapping pointer increment used by the top level.
package async_fifo_pkg;

    localparam int DEF_DSIZE = 8;
    localparam int DEF_ASIZE = 4;

    // Pointer carries one extra wrap bit above the memory address.
    localparam int PTR_W = DEF_ASIZE + 1;
    typedef logic [PTR_W-1:0] ptr_t;

    // Increment a pointer of 'width' bits, wrapping modulo 2**width.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (ptr + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DSIZE x 2**ASIZE words, registered write port and
// combinational read port. The array is deliberately not reset.
module fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int DSIZE = DEF_DSIZE,
    parameter int ASIZE = DEF_ASIZE
) (
    input  logic             i_clk,
    input  logic             i_wen,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] r_mem [DEPTH];

    // Capture the write word on an accepted write.
    always_ff @(posedge i_clk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/async_fifo_1clk.sv
// Single-clock FIFO exposing the dual-clock async_fifo port set.
// Pointers are ASIZE+1 bits (wrap bit on top); flags are registered from
// the next-state pointers. First-word-fall-through read data.
// Optional feature: define ASYNC_FIFO_COUNT_EN to add the registered
// occupancy output wcount [ASIZE:0].
module async_fifo_1clk
    import async_fifo_pkg::*;
#(
    parameter int DSIZE = DEF_DSIZE,
    parameter int ASIZE = DEF_ASIZE
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty
`ifdef ASYNC_FIFO_COUNT_EN
    ,
    output logic [ASIZE:0]   wcount
`endif
);

    localparam int PW = ASIZE + 1;

    logic [ASIZE:0] r_wptr;
    logic [ASIZE:0] r_rptr;
    logic [ASIZE:0] w_wptr_next;
    logic [ASIZE:0] w_rptr_next;
    logic           r_wfull;
    logic           r_rempty;
    logic           w_wen;
    logic           w_ren;
    logic           w_wfull_next;
    logic           w_rempty_next;

    // Requests against the registered flags: full blocks writes, empty blocks
    // reads, which also resolves the simultaneous empty/full cases.
    assign w_wen = winc && !r_wfull;
    assign w_ren = rinc && !r_rempty;

    assign w_wptr_next = w_wen ? PW'(ptr_inc(32'(r_wptr), PW)) : r_wptr;
    assign w_rptr_next = w_ren ? PW'(ptr_inc(32'(r_rptr), PW)) : r_rptr;

    // Equal pointers mean empty; equal address with opposite wrap bit means full.
    assign w_rempty_next = (w_wptr_next == w_rptr_next);
    assign w_wfull_next  = (w_wptr_next == {~w_rptr_next[ASIZE], w_rptr_next[ASIZE-1:0]});

    // Pointer and flag state, cleared immediately by reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_wfull  <= 1'b0;
            r_rempty <= 1'b1;
        end else begin
            r_wptr   <= w_wptr_next;
            r_rptr   <= w_rptr_next;
            r_wfull  <= w_wfull_next;
            r_rempty <= w_rempty_next;
        end
    end

    assign wfull  = r_wfull;
    assign rempty = r_rempty;

`ifdef ASYNC_FIFO_COUNT_EN
    logic [ASIZE:0] r_wcount;

    // Occupancy from the next-state pointers; modular difference spans 0..2**ASIZE.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wcount <= '0;
        end else begin
            r_wcount <= w_wptr_next - w_rptr_next;
        end
    end

    assign wcount = r_wcount;
`endif

    fifo_mem #(
        .DSIZE(DSIZE),
        .ASIZE(ASIZE)
    ) u_mem (
        .i_clk   (wclk),
        .i_wen   (w_wen),
        .i_waddr (r_wptr[ASIZE-1:0]),
        .i_wdata (wdata),
        .i_raddr (r_rptr[ASIZE-1:0]),
        .o_rdata (rdata)
    );

endmodule

// File: tb/tb_async_fifo_1clk.sv
// Bench for async_fifo_1clk (DSIZE=8, ASIZE=6): queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_async_fifo_1clk;

    localparam int DSIZE = 8;
    localparam int ASIZE = 6;
    localparam int DEPTH = 1 << ASIZE;

    logic             wclk = 1'b0;
    logic             wrst_n = 1'b0;
    logic             winc = 1'b0;
    logic [DSIZE-1:0] wdata = '0;
    logic             wfull;
    logic             rinc = 1'b0;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
`ifdef ASYNC_FIFO_COUNT_EN
    logic [ASIZE:0]   wcount;
`endif

    int n_chk = 0;
    int n_pass = 0;

    logic [DSIZE-1:0] model_q[$];

    async_fifo_1clk #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .winc   (winc),
        .wdata  (wdata),
        .wfull  (wfull),
        .rinc   (rinc),
        .rdata  (rdata),
        .rempty (rempty)
`ifdef ASYNC_FIFO_COUNT_EN
        ,
        .wcount (wcount)
`endif
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a plain queue of words, occupancy limited to DEPTH.
    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            model_q.delete();
        end else begin
            automatic bit do_w = winc && (model_q.size() < DEPTH);
            automatic bit do_r = rinc && (model_q.size() > 0);
            if (do_r) void'(model_q.pop_front());
            if (do_w) model_q.push_back(wdata);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge wclk) begin
        if (wrst_n) begin
            chk("m_rempty", 32'(rempty), 32'(model_q.size() == 0));
            chk("m_wfull", 32'(wfull), 32'(model_q.size() == DEPTH));
            if (model_q.size() > 0) chk("m_rdata", 32'(rdata), 32'(model_q[0]));
`ifdef ASYNC_FIFO_COUNT_EN
            chk("m_wcount", 32'(wcount), 32'(model_q.size()));
`endif
        end
    end

    // One clock with the given requests; returns 1 time unit after the edge.
    task automatic step(input logic w, input logic [DSIZE-1:0] d, input logic r);
        winc = w;
        wdata = d;
        rinc = r;
        @(posedge wclk);
        #1;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    logic [DSIZE-1:0] exp_arr [30];

    initial begin
        // 1 Reset
        wrst_n = 1'b0;
        repeat (10) @(posedge wclk);
        #1;
        chk("rst_rempty", 32'(rempty), 32'd1);
        chk("rst_wfull", 32'(wfull), 32'd0);
`ifdef ASYNC_FIFO_COUNT_EN
        chk("rst_wcount", 32'(wcount), 32'd0);
`endif
        wrst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        chk("rel_rempty", 32'(rempty), 32'd1);
        chk("rel_wfull", 32'(wfull), 32'd0);

        // 2 Fill
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 0) begin
                chk("first_rempty", 32'(rempty), 32'd0);
                chk("first_rdata", 32'(rdata), 32'h00);
            end
            if (i == DEPTH - 2) chk("almost_wfull", 32'(wfull), 32'd0);
        end
        chk("fill_wfull", 32'(wfull), 32'd1);
        step(1'b1, 8'hAA, 1'b0);
        chk("ovf_head", 32'(rdata), 32'h00);
        chk("ovf_wfull", 32'(wfull), 32'd1);

        // 3 Drain
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_rdata", 32'(rdata), 32'(i));
            step(1'b0, 8'h00, 1'b1);
            if (i == 0) chk("drain_wfull", 32'(wfull), 32'd0);
        end
        chk("drain_rempty", 32'(rempty), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("udf_rempty", 32'(rempty), 32'd1);
        step(1'b1, 8'h55, 1'b0);
        chk("udf_head", 32'(rdata), 32'h55);
        step(1'b0, 8'h00, 1'b1);
        chk("udf_empty2", 32'(rempty), 32'd1);

        // 4 Wrap: bursts of 30 writes then 30 reads, twice
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 30; i++) begin
                exp_arr[i] = 8'($urandom);
                step(1'b1, exp_arr[i], 1'b0);
            end
            for (int i = 0; i < 30; i++) begin
                chk("wrap_rdata", 32'(rdata), 32'(exp_arr[i]));
                step(1'b0, 8'h00, 1'b1);
            end
            chk("wrap_rempty", 32'(rempty), 32'd1);
        end

        // 5 Simultaneous requests
        step(1'b1, 8'h11, 1'b1);
        chk("sim_e_rempty", 32'(rempty), 32'd0);
        chk("sim_e_rdata", 32'(rdata), 32'h11);
        for (int k = 1; k < DEPTH; k++) step(1'b1, 8'(8'h80 + k), 1'b0);
        chk("sim_f_wfull0", 32'(wfull), 32'd1);
        step(1'b1, 8'hEE, 1'b1);
        chk("sim_f_wfull", 32'(wfull), 32'd0);
        chk("sim_f_rdata", 32'(rdata), 32'h81);
        for (int k = 0; k < 31; k++) step(1'b0, 8'h00, 1'b1);
        chk("sim_h_rdata0", 32'(rdata), 32'hA0);
        step(1'b1, 8'hCC, 1'b1);
        chk("sim_h_rdata", 32'(rdata), 32'hA1);
        chk("sim_h_flags", 32'({wfull, rempty}), 32'd0);
`ifdef ASYNC_FIFO_COUNT_EN
        chk("sim_h_wcount", 32'(wcount), 32'd32);
`endif
        for (int k = 0; k < 31; k++) step(1'b0, 8'h00, 1'b1);
        chk("sim_tail", 32'(rdata), 32'hCC);
        step(1'b0, 8'h00, 1'b1);
        chk("sim_end_empty", 32'(rempty), 32'd1);

        // 6 Mid-operation reset
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        chk("pre_rst_rdata", 32'(rdata), 32'h30);
        #3;
        wrst_n = 1'b0;
        #1;
        chk("mid_rst_rempty", 32'(rempty), 32'd1);
        chk("mid_rst_wfull", 32'(wfull), 32'd0);
`ifdef ASYNC_FIFO_COUNT_EN
        chk("mid_rst_wcount", 32'(wcount), 32'd0);
`endif
        #1;
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        step(1'b1, 8'h5A, 1'b0);
        chk("post_rst_rdata", 32'(rdata), 32'h5A);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_empty", 32'(rempty), 32'd1);

        step(1'b0, 8'h00, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
